// File: rtl/seq_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Define DIV_CHECK_EN to add a quotient*divisor+remainder self-check that drives check_err.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_zero,
  output logic                 ovf,
  output logic                 check_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Partial remainder is kept at WIDTH bits: it is always below the divisor.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             ovf_q, ovf_d;
  logic             check_err_q, check_err_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] q_shift;
  logic [WIDTH-1:0] diff;
  logic             sub_ok;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;
  logic             last_iter;
  logic             accept;
  logic             check_fail;

`ifdef DIV_CHECK_EN
  logic [2*WIDTH-1:0] dividend_q, dividend_d;
  logic [2*WIDTH-1:0] recomposed;
`endif

  // One restoring step: shift {R,Q} left, subtract divisor if it fits.
  always_comb begin
    r_shift   = {r_q, q_q[WIDTH-1]};
    q_shift   = {q_q[WIDTH-2:0], 1'b0};
    sub_ok    = (r_shift >= {1'b0, divisor_q});
    diff      = r_shift[WIDTH-1:0] - divisor_q;
    r_step    = sub_ok ? diff : r_shift[WIDTH-1:0];
    q_step    = sub_ok ? (q_shift | {{(WIDTH-1){1'b0}}, 1'b1}) : q_shift;
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

`ifdef DIV_CHECK_EN
  always_comb begin
    recomposed = {{WIDTH{1'b0}}, q_step} * {{WIDTH{1'b0}}, divisor_q}
               + {{WIDTH{1'b0}}, r_step};
    check_fail = (recomposed != dividend_q);
  end
`else
  assign check_fail = 1'b0;
`endif

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    divisor_d   = divisor_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;
    check_err_d = check_err_q;
`ifdef DIV_CHECK_EN
    dividend_d  = dividend_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          divisor_d   = divisor;
`ifdef DIV_CHECK_EN
          dividend_d  = dividend;
`endif
          check_err_d = 1'b0;
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = '0;
            div_zero_d  = 1'b1;
            ovf_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            quotient_d  = '1;
            remainder_d = '0;
            div_zero_d  = 1'b0;
            ovf_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            r_d         = dividend[2*WIDTH-1:WIDTH];
            q_d         = dividend[WIDTH-1:0];
            cnt_d       = '0;
            div_zero_d  = 1'b0;
            ovf_d       = 1'b0;
            state_d     = CALC;
          end
        end
      end
      CALC: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          quotient_d  = q_step;
          remainder_d = r_step;
          check_err_d = check_fail;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      divisor_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
      check_err_q <= 1'b0;
`ifdef DIV_CHECK_EN
      dividend_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      divisor_q   <= divisor_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
      check_err_q <= check_err_d;
`ifdef DIV_CHECK_EN
      dividend_q  <= dividend_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign ovf       = ovf_q;
  assign check_err = check_err_q;

endmodule
